// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared types and helpers for the layer-0 write-back path.
//   fp16_t          : one FP16 pixel
//   WORD_BITS       : width of one feature-map BRAM word (16 pixels)
//   writer_state_e  : fmap_col_writer control states
//   pack_word()     : extracts word w of a packed column, zero-padding rows
//                     beyond the column height
// -----------------------------------------------------------------------------
package cnn_pkg;

   typedef logic [15:0] fp16_t;

   localparam int unsigned PIX_W        = 16;
   localparam int unsigned MAP_SIZE     = 24;
   localparam int unsigned PIX_PER_WORD = 16;
   localparam int unsigned WORD_BITS    = PIX_W * PIX_PER_WORD;
   localparam int unsigned COL_BITS     = PIX_W * MAP_SIZE;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } writer_state_e;

   // Lane j of word w carries row w*PIX_PER_WORD+j; rows past the bottom of
   // the column read as zero so the last word of a column is padded.
   function automatic logic [WORD_BITS-1:0] pack_word(
      input logic [COL_BITS-1:0] col,
      input int unsigned         w
   );
      logic [WORD_BITS-1:0] word;
      fp16_t                pix;
      int unsigned          row;
      word = '0;
      for (int unsigned j = 0; j < PIX_PER_WORD; j++) begin
         row = w * PIX_PER_WORD + j;
         if (row < MAP_SIZE) begin
            pix = col[row*PIX_W +: PIX_W];
            word[j*PIX_W +: PIX_W] = pix;
         end
      end
      return word;
   endfunction

endpackage

// File: rtl/col_fifo.sv
// -----------------------------------------------------------------------------
// col_fifo
// Small synchronous FIFO holding whole columns. The head entry is visible
// combinationally on `head`; push while full and pop while empty are ignored.
// DEPTH must be a power of two (pointers wrap naturally), at least 2.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push/wdata : write one entry
//   pop        : discard the head entry
//   head       : current head entry
//   full/empty : occupancy flags
//   count      : number of stored entries
// -----------------------------------------------------------------------------
module col_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read after it
   // has been written, so resetting the pointers and count is sufficient.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fmap_col_writer.sv
// -----------------------------------------------------------------------------
// fmap_col_writer
// Buffers output columns of the layer-0 convolution and writes each one to the
// feature-map BRAM as WORDS_PER_COL zero-padded 256-bit words at
// addr = BASE_ADDR + col*WORDS_PER_COL + w (column-major, next layer's layout).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : arm for a new feature map (IDLE only)
//   col_valid/col_ready : column handshake; col_num + col_data (row i = elem i)
//   wr_ready            : BRAM port grant; no word is issued while low
//   wr_en/wr_addr/wr_data : registered BRAM write port
//   done                : one-cycle pulse after the last word of the map
//   busy                : high from start until done
//   err_overflow        : sticky, a column arrived while the buffer was full
//   err_order           : sticky, a column index broke the 0,1,2,... sequence
// -----------------------------------------------------------------------------
module fmap_col_writer
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned OUT_SIZE      = 24,
   parameter int unsigned WORD_PIX      = 16,
   parameter int unsigned WORDS_PER_COL = 2,
   parameter int unsigned ADDR_WIDTH    = 12,
   parameter int unsigned BASE_ADDR     = 0,
   parameter int unsigned FIFO_DEPTH    = 2,
   localparam int unsigned COL_NUM_W    = $clog2(OUT_SIZE) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           col_valid,
   input  logic [COL_NUM_W-1:0]           col_num,
   input  logic [DATA_WIDTH-1:0]          col_data [OUT_SIZE-1:0],
   output logic                           col_ready,
   input  logic                           wr_ready,
   output logic                           wr_en,
   output logic [ADDR_WIDTH-1:0]          wr_addr,
   output logic [DATA_WIDTH*WORD_PIX-1:0] wr_data,
   output logic                           done,
   output logic                           busy,
   output logic                           err_overflow,
   output logic                           err_order
);

   localparam int unsigned COL_W   = DATA_WIDTH * OUT_SIZE;
   localparam int unsigned ENTRY_W = COL_NUM_W + COL_W;
   localparam int unsigned WIDX_W  = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

   writer_state_e          state, next_state;
   logic [COL_NUM_W-1:0]   col_seen;   // columns seen this map, accepted or dropped
   logic [WIDX_W-1:0]      word_idx;
   logic [COL_W-1:0]       col_packed;
   logic [ENTRY_W-1:0]     head;
   logic [COL_NUM_W-1:0]   head_num;
   logic [COL_W-1:0]       head_col;
   logic [ADDR_WIDTH-1:0]  word_addr;
   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic                   last_word;

   for (genvar i = 0; i < OUT_SIZE; i++) begin : g_pack
      assign col_packed[i*DATA_WIDTH +: DATA_WIDTH] = col_data[i];
   end

   // Ready comes from the registered occupancy only: a column is never
   // accepted into a full buffer on the strength of a same-cycle pop.
   assign col_ready = (state == RUN) && !fifo_full;
   assign push      = col_valid && col_ready;

   assign head_num  = head[ENTRY_W-1 -: COL_NUM_W];
   assign head_col  = head[COL_W-1:0];
   assign issue     = !fifo_empty && wr_ready;
   assign last_word = (word_idx == WIDX_W'(WORDS_PER_COL - 1));
   assign pop       = issue && last_word;
   assign word_addr = ADDR_WIDTH'(BASE_ADDR)
                    + ADDR_WIDTH'(head_num) * ADDR_WIDTH'(WORDS_PER_COL)
                    + ADDR_WIDTH'(word_idx);

   col_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({col_num, col_packed}),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      done       = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) next_state = RUN;
         end
         RUN: begin
            busy = 1'b1;
            // The OUT_SIZE-th column ends the input phase even if it is dropped.
            if (col_valid && col_seen == COL_NUM_W'(OUT_SIZE - 1)) next_state = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (fifo_count == '0) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         col_seen     <= '0;
         err_overflow <= 1'b0;
         err_order    <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && start) begin
            col_seen     <= '0;
            err_overflow <= 1'b0;
            err_order    <= 1'b0;
         end else if (state == RUN && col_valid) begin
            col_seen <= col_seen + COL_NUM_W'(1);
            if (!col_ready)                err_overflow <= 1'b1;
            else if (col_num != col_seen)  err_order    <= 1'b1;
         end
      end
   end

   // Write port: a word is decided while wr_ready is high and presented on
   // wr_en/wr_addr/wr_data in the following cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         word_idx <= '0;
      end else begin
         wr_en <= issue;
         if (issue) begin
            wr_addr  <= word_addr;
            wr_data  <= pack_word(head_col, 32'(word_idx));
            word_idx <= last_word ? '0 : word_idx + WIDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fmap_col_writer.sv
// -----------------------------------------------------------------------------
// tb_fmap_col_writer
// Directed bench for fmap_col_writer. Column c carries row i = 16'h3C00+c*32+i,
// so column 0 is 3C00+i. Inputs change 1 ns after the rising edge; outputs are
// logged on the falling edge.
// -----------------------------------------------------------------------------
module tb_fmap_col_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        col_valid;
   logic [5:0]  col_num;
   logic [15:0] col_data [23:0];
   logic        col_ready;
   logic        wr_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [255:0] wr_data;
   logic        done;
   logic        busy;
   logic        err_overflow;
   logic        err_order;

   always #5 clk = ~clk;

   fmap_col_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .col_valid    (col_valid),
      .col_num      (col_num),
      .col_data     (col_data),
      .col_ready    (col_ready),
      .wr_ready     (wr_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .done         (done),
      .busy         (busy),
      .err_overflow (err_overflow),
      .err_order    (err_order)
   );

   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic        prev_ready = 1'b1;
   int          stall_viol = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   logic        busy_at_done = 1'b0;
   logic [11:0] wa_q [$];
   logic [255:0] wd_q [$];
   int          wc_q [$];

   always @(posedge clk) begin
      cyc++;
      prev_ready = wr_ready;
   end

   always @(negedge clk) begin
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
         wc_q.push_back(cyc);
         if (!prev_ready) stall_viol++;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [255:0] exp_word(input int c, input int w);
      logic [255:0] v;
      v = '0;
      for (int j = 0; j < 16; j++) begin
         int r;
         r = w * 16 + j;
         if (r < 24) v[j*16 +: 16] = 16'h3C00 + 16'(c * 32 + r);
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_col(input int num);
      col_num = 6'(num);
      for (int i = 0; i < 24; i++) col_data[i] = 16'h3C00 + 16'(num * 32 + i);
   endtask

   task automatic send_col(input int num, output logic acc);
      set_col(num);
      col_valid = 1'b1;
      acc = col_ready;
      tick();
      col_valid = 1'b0;
   endtask

   // Producer cadence: one column every two cycles.
   task automatic run_cols(input int lo, input int hi);
      logic a;
      for (int c = lo; c <= hi; c++) begin
         send_col(c, a);
         tick();
      end
   endtask

   task automatic start_map();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      done_cnt = 0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, done_cnt, 1);
   endtask

   task automatic addr_run_check(input string tag, input int first_idx, input int n, input int first_addr);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (first_idx + i >= wa_q.size()) bad++;
         else if (wa_q[first_idx+i] !== 12'(first_addr + i) ||
                  wd_q[first_idx+i] !== exp_word((first_addr + i) / 2, (first_addr + i) % 2)) bad++;
      end
      check(tag, bad, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic a0, a3, a4, r0, r1, r2;
      int   n0, b;

      rst_n     = 1'b0;
      start     = 1'b0;
      col_valid = 1'b0;
      wr_ready  = 1'b1;
      set_col(0);
      repeat (3) tick();

      check("rst_ctrl", {wr_en, done, busy, col_ready, err_overflow, err_order}, 6'b0);
      check("rst_addr", wr_addr, 12'd0);
      check("rst_data", wr_data, 256'd0);
      rst_n = 1'b1;
      tick();

      // ---- single column detail + full map at producer cadence ----
      clear_log();
      start_map();
      check("run_busy", busy, 1'b1);
      check("run_col_ready", col_ready, 1'b1);
      send_col(0, a0);
      n0 = cyc;
      tick();
      run_cols(1, 23);
      wait_done("map");
      repeat (3) tick();
      check("col0_w0_cycle", wc_q[0], n0 + 1);
      check("col0_w1_cycle", wc_q[1], n0 + 2);
      check("col0_w0_addr", wa_q[0], 12'd0);
      check("col0_w0_data", wd_q[0], exp_word(0, 0));
      check("col0_w0_lane1", wd_q[0][31:16], 16'h3C01);
      check("col0_w1_addr", wa_q[1], 12'd1);
      check("col0_w1_lane0", wd_q[1][15:0], 16'h3C10);
      check("col0_w1_lane7", wd_q[1][127:112], 16'h3C17);
      check("col0_w1_pad", wd_q[1][255:128], 128'd0);
      check("map_count", wa_q.size(), 48);
      addr_run_check("map_words", 0, 48, 0);
      check("map_done_cyc", done_cyc, wc_q[$] + 1);
      check("map_done_once", done_cnt, 1);
      check("map_busy_at_done", busy_at_done, 1'b0);
      check("map_busy_after", busy, 1'b0);
      check("map_errs", {err_overflow, err_order}, 2'b00);

      // ---- backpressure ----
      clear_log();
      start_map();
      run_cols(0, 2);
      repeat (4) tick();
      clear_log();
      b = cyc;
      wr_ready = 1'b0;
      send_col(3, a3);
      tick();
      send_col(4, a4);
      check("bp_ready_full", col_ready, 1'b0);
      tick();
      tick();
      check("bp_no_write_stalled", wa_q.size(), 0);
      wr_ready = 1'b1;
      repeat (6) tick();
      check("bp_accept", {a3, a4}, 2'b11);
      check("bp_count", wa_q.size(), 4);
      check("bp_first_cycle", wc_q[0], b + 6);
      addr_run_check("bp_words", 0, 4, 6);
      run_cols(5, 23);
      wait_done("bp");
      check("bp_errs", {err_overflow, err_order}, 2'b00);

      // ---- overflow ----
      clear_log();
      start_map();
      wr_ready  = 1'b0;
      col_valid = 1'b1;
      set_col(0);
      r0 = col_ready;
      tick();
      set_col(1);
      r1 = col_ready;
      tick();
      set_col(2);
      r2 = col_ready;
      tick();
      col_valid = 1'b0;
      check("ovf_ready_seq", {r0, r1, r2}, 3'b110);
      check("ovf_flag", err_overflow, 1'b1);
      check("ovf_no_write", wa_q.size(), 0);
      wr_ready = 1'b1;
      repeat (6) tick();
      check("ovf_count", wa_q.size(), 4);
      addr_run_check("ovf_words", 0, 4, 0);
      run_cols(3, 23);
      wait_done("ovf");
      check("ovf_total", wa_q.size(), 46);
      check("ovf_sticky", {err_overflow, err_order}, 2'b10);

      // ---- order error ----
      clear_log();
      start_map();
      send_col(0, a0);
      tick();
      send_col(1, a0);
      tick();
      check("ord_clean", err_order, 1'b0);
      send_col(3, a0);
      check("ord_flag", err_order, 1'b1);
      tick();
      run_cols(4, 24);
      wait_done("ord");
      check("ord_count", wa_q.size(), 48);
      check("ord_c3_addr", {wa_q[4], wa_q[5]}, {12'd6, 12'd7});
      check("ord_c3_w0", wd_q[4], exp_word(3, 0));
      check("ord_c3_w1", wd_q[5], exp_word(3, 1));
      check("ord_unclamped", {wa_q[46], wa_q[47]}, {12'd48, 12'd49});
      check("ord_flags", {err_overflow, err_order}, 2'b01);

      // ---- reset mid-map ----
      clear_log();
      start_map();
      run_cols(0, 9);
      send_col(10, a0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_ctrl", {wr_en, done, busy, col_ready, err_overflow, err_order, wr_addr}, 18'd0);
      check("mid_rst_data", wr_data, 256'd0);
      clear_log();
      for (int i = 0; i < 10; i++) begin
         col_valid = i[0];
         set_col(i);
         tick();
      end
      col_valid = 1'b0;
      check("mid_rst_quiet", {32'(wa_q.size()), 32'(done_cnt), 31'd0, busy}, 96'd0);
      check("mid_rst_idle_noerr", err_overflow, 1'b0);
      start_map();
      send_col(0, a0);
      repeat (4) tick();
      check("restart_count", wa_q.size(), 2);
      addr_run_check("restart_words", 0, 2, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
